// File: rtl/fb_pkg.sv
// Framebuffer arbiter shared definitions: default geometry and grant encoding.
package fb_pkg;
  localparam int FB_ADDR_WIDTH = 10;
  localparam int FB_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    HOST = 2'd2
  } grant_e;
endpackage

// File: rtl/host_fifo.sv
// Two-entry synchronous FIFO for queued host RAM transactions; head visible the cycle after push.
// Caller guards push with !full and pop with !empty; full stays asserted through a pop cycle.
module host_fifo #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/fb_ram_arbiter.sv
// Shares the framebuffer RAM between scan-out (strict priority) and queued host accesses.
// Display data 1 cycle after request; host min 2 cycles after accept; host_ready drops when the 2-entry queue is full.
module fb_ram_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_valid,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  grant_e                grant;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ENTRY_W-1:0]    fifo_head;
  logic                  head_we;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  disp_flag_q;
  logic                  host_flag_q;

  assign host_ready = ~fifo_full;
  assign fifo_push  = host_valid & host_ready;
  assign fifo_pop   = (grant == HOST);

  host_fifo #(.WIDTH(ENTRY_W)) u_host_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({host_we, host_addr, host_wdata}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign {head_we, head_addr, head_wdata} = fifo_head;

  always_comb begin
    grant = IDLE;
    if (rst)              grant = IDLE;
    else if (disp_req)    grant = DISP;
    else if (!fifo_empty) grant = HOST;
  end

  // Idle cycles park the address on its last value to avoid needless toggling.
  always_comb begin
    ram_addr = addr_q;
    case (grant)
      DISP:    ram_addr = disp_addr;
      HOST:    ram_addr = head_addr;
      default: ram_addr = addr_q;
    endcase
  end

  assign ram_din = head_wdata;
  assign ram_we  = (grant == HOST) & head_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      disp_flag_q <= 1'b0;
      host_flag_q <= 1'b0;
    end else begin
      addr_q      <= ram_addr;
      disp_flag_q <= (grant == DISP);
      host_flag_q <= (grant == HOST) & ~head_we;
    end
  end

  // A read launched just before reset must not report in the reset cycle itself.
  assign disp_valid  = disp_flag_q & ~rst;
  assign host_rvalid = host_flag_q & ~rst;
  assign disp_data   = ram_dout;
  assign host_rdata  = ram_dout;
endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Directed bench for fb_ram_arbiter with a behavioural 1024x4 registered-read RAM.
module tb_fb_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       disp_req;
  logic [9:0] disp_addr;
  logic [3:0] disp_data;
  logic       disp_valid;
  logic       host_valid;
  logic       host_ready;
  logic       host_we;
  logic [9:0] host_addr;
  logic [3:0] host_wdata;
  logic [3:0] host_rdata;
  logic       host_rvalid;
  logic [9:0] ram_addr;
  logic [3:0] ram_din;
  logic       ram_we;
  logic [3:0] ram_dout;

  logic [3:0] mem [1024];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fb_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic host_idle();
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic host_offer(input logic we, input logic [9:0] a, input logic [3:0] d);
    host_valid = 1'b1; host_we = we; host_addr = a; host_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    for (int i = 0; i < 8; i++) mem[i] = 4'(i);
    mem[10'h010] = 4'h1;
    ram_dout = '0;
    rst = 1'b1; disp_req = 1'b0; disp_addr = '0;
    host_idle();
    next_cycle(); next_cycle();

    // Reset release
    rst = 1'b0;
    sample();
    check("rst_host_ready", host_ready, 1);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_ram_we", ram_we, 0);
    next_cycle();

    // Display burst over 0..7
    for (int i = 0; i <= 9; i++) begin
      disp_req  = (i < 8);
      disp_addr = 10'(i);
      sample();
      if (i >= 1 && i <= 8) begin
        check($sformatf("disp_valid_%0d", i - 1), disp_valid, 1);
        check($sformatf("disp_data_%0d", i - 1), disp_data, i - 1);
      end else begin
        check($sformatf("disp_valid_edge_%0d", i), disp_valid, 0);
      end
      check("disp_ram_we", ram_we, 0);
      next_cycle();
    end

    // Host write then read, same address
    disp_req = 1'b0;
    host_offer(1'b1, 10'h3A5, 4'hC);
    sample();
    check("wr_accept_ready", host_ready, 1);
    check("wr_not_same_cycle", ram_we, 0);
    next_cycle();
    host_offer(1'b0, 10'h3A5, 4'h0);
    sample();
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_addr, 10'h3A5);
    check("wr_ram_din", ram_din, 4'hC);
    next_cycle();
    host_idle();
    sample();
    check("rd_ram_we", ram_we, 0);
    check("rd_ram_addr", ram_addr, 10'h3A5);
    check("wr_no_rvalid", host_rvalid, 0);
    next_cycle();
    sample();
    check("rd_rvalid", host_rvalid, 1);
    check("rd_rdata", host_rdata, 4'hC);
    next_cycle();
    sample();
    check("rd_rvalid_once", host_rvalid, 0);
    next_cycle();

    // Host starved by a 20-cycle display run
    for (int i = 0; i < 20; i++) begin
      disp_req = 1'b1; disp_addr = 10'(100 + i);
      if (i == 0)      host_offer(1'b1, 10'h020, 4'h5);
      else if (i == 1) host_offer(1'b1, 10'h021, 4'h6);
      else             host_offer(1'b1, 10'h022, 4'h7);
      sample();
      check($sformatf("starve_ready_%0d", i), host_ready, (i < 2) ? 1 : 0);
      check($sformatf("starve_we_%0d", i), ram_we, 0);
      next_cycle();
    end
    disp_req = 1'b0;
    sample();
    check("drain0_we", ram_we, 1);
    check("drain0_addr", ram_addr, 10'h020);
    check("drain0_din", ram_din, 4'h5);
    check("drain0_ready_full", host_ready, 0);
    next_cycle();
    sample();
    check("drain1_we", ram_we, 1);
    check("drain1_addr", ram_addr, 10'h021);
    check("drain1_din", ram_din, 4'h6);
    check("drain1_ready", host_ready, 1);
    next_cycle();
    host_idle();
    sample();
    check("drain2_we", ram_we, 1);
    check("drain2_addr", ram_addr, 10'h022);
    check("drain2_din", ram_din, 4'h7);
    next_cycle();
    sample();
    check("idle_we", ram_we, 0);
    check("idle_addr_hold", ram_addr, 10'h022);
    next_cycle();

    // Display read races a queued host write: old data first, new data later
    host_offer(1'b1, 10'h010, 4'h9);
    sample();
    next_cycle();
    host_idle();
    disp_req = 1'b1; disp_addr = 10'h010;
    sample();
    check("race_disp_priority_we", ram_we, 0);
    next_cycle();
    disp_req = 1'b0;
    sample();
    check("race_old_valid", disp_valid, 1);
    check("race_old_data", disp_data, 4'h1);
    check("race_write_we", ram_we, 1);
    next_cycle();
    disp_req = 1'b1; disp_addr = 10'h010;
    sample();
    next_cycle();
    disp_req = 1'b0;
    sample();
    check("race_new_valid", disp_valid, 1);
    check("race_new_data", disp_data, 4'h9);
    next_cycle();

    // Reset with a read in flight and one entry queued
    host_offer(1'b0, 10'h3A5, 4'h0);
    sample();
    next_cycle();
    host_offer(1'b1, 10'h011, 4'hF);
    sample();
    check("rr_read_granted_addr", ram_addr, 10'h3A5);
    check("rr_read_we", ram_we, 0);
    next_cycle();
    host_idle();
    rst = 1'b1;
    sample();
    check("rr_rvalid_in_reset", host_rvalid, 0);
    check("rr_we_in_reset", ram_we, 0);
    check("rr_disp_valid_in_reset", disp_valid, 0);
    next_cycle();
    rst = 1'b0;
    sample();
    check("rr_ready_after", host_ready, 1);
    check("rr_we_after", ram_we, 0);
    check("rr_rvalid_after", host_rvalid, 0);
    next_cycle();
    sample();
    check("rr_discarded_we", ram_we, 0);
    next_cycle();
    sample();
    check("rr_mem_untouched", mem[10'h011], 4'h0);
    check("rr_mem_kept", mem[10'h3A5], 4'hC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fb_ram_arbiter.md
# fb_ram_arbiter

Shares the single-port 1024x4 framebuffer RAM between the VGA scan-out reader and a host port (UART/CPU loader) in the VGA project. The display path has strict priority and a fixed 1-cycle read latency. Host reads and writes are queued in a 2-entry FIFO and issued in idle RAM cycles. The block sits between the pixel timing logic and the `ram` instance and drives all of that instance's ports.

## Interface
- `ADDR_WIDTH`, 10, RAM address width.
- `DATA_WIDTH`, 4, RAM word width.

- `clk`  in  1  single clock; RAM and arbiter share it.
- `rst`  in  1  synchronous, active-high reset.
- `disp_req`  in  1  display read request this cycle.
- `disp_addr`  in  ADDR_WIDTH  display read address.
- `disp_data`  out  DATA_WIDTH  read data; equals `ram_dout`.
- `disp_valid`  out  1  `disp_data` valid; registered.
- `host_valid`  in  1  host transaction offered.
- `host_ready`  out  1  FIFO can accept.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  ADDR_WIDTH  host address.
- `host_wdata`  in  DATA_WIDTH  host write data.
- `host_rdata`  out  DATA_WIDTH  host read data; equals `ram_dout`.
- `host_rvalid`  out  1  `host_rdata` valid; registered.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_din`  out  DATA_WIDTH  to RAM `din`.
- `ram_we`  out  1  to RAM `write_en`.
- `ram_dout`  in  DATA_WIDTH  from RAM `dout`, 1-cycle registered read.

## Operation
- Grant is decided each cycle, combinationally:
  - `disp_req` = 1 -> grant DISP. `ram_addr` = `disp_addr`, `ram_we` = 0.
  - else FIFO non-empty -> grant HOST. `ram_addr`, `ram_din` and `ram_we` come from the FIFO head, and the head pops at the clock edge.
  - else IDLE. `ram_we` = 0 and `ram_addr` holds its last value (no toggling).
- In every cycle where `rst` = 1, the grant is forced to IDLE.
- Host FIFO:
  - Depth 2, with occupancy count 0..2.
  - `host_ready` = (count != 2).
  - Push on `host_valid && host_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - A pushed entry is never granted in its push cycle.
  - When full, `host_ready` = 0 even if a pop occurs in that cycle.
- Return tagging: two registered flags, `disp_valid` <= (grant == DISP) and `host_rvalid` <= (grant == HOST && !head.we). Writes produce no `host_rvalid`.
- Ordering:
  - Host transactions complete in acceptance order.
  - A host write followed by a host read to the same address returns the new data.
  - A display read issued in the same cycle the host write would have been issued returns the old data, because the host write waits.
- Starvation: the host can be starved indefinitely while `disp_req` is held. The scan-out drops `disp_req` during blanking, and that is the host's service window. No timeout.

## Timing
- Reset values: `disp_valid` = 0, `host_rvalid` = 0, FIFO count = 0, `ram_we` = 0, `host_ready` = 1 in the cycle after reset deasserts.
- Display latency: `disp_req` in cycle t -> `disp_valid` = 1 with data in t+1. Back-to-back every cycle, no bubbles.
- Host minimum latency: accept in a, grant in a+1, `host_rvalid` in a+2. A write is committed at the end of a+1.
- Reset mid-operation:
  - Queued entries are discarded.
  - A read granted in the cycle before `rst` still has its flag cleared, so no valid pulse appears in the reset cycle.
  - No RAM write occurs during reset.
- RAM contents are not affected by reset.

## Structure
- Package `fb_pkg`: defaults `FB_ADDR_WIDTH` = 10, `FB_DATA_WIDTH` = 4, and the grant encoding constants IDLE/DISP/HOST.
- Sub-module `host_fifo`: 2-entry synchronous FIFO with entry {we, addr, wdata}, signals push/pop/full/empty and the head outputs.
- The arbiter mux and the return flags live in the top module.

## Test plan
- Idle host, `disp_req` held 8 cycles over addresses 0..7 with RAM preloaded to 0..7 -> `disp_valid` high 8 consecutive cycles starting 1 cycle later, data 0..7.
- `disp_req` = 0, host write 0x3A5 <= 4'hC then read 0x3A5 -> `ram_we` pulses once, `host_rvalid` is 1 cycle with data 4'hC, order preserved.
- `disp_req` held 20 cycles while host offers 3 writes -> 2 accepted, `host_ready` = 0 and `ram_we` = 0 throughout; when `disp_req` drops, the writes issue in the next 2 cycles and the third is then accepted.
- Host write 4'h9 to 0x010 queued, display reads 0x010 in the same cycle (old value 4'h1) -> `disp_data` = 1; a later display read returns 9.
- Host read granted at cycle t, `rst` asserted at t+1 with 1 entry queued -> `host_rvalid` = 0 at t+1, the queued entry is never issued, `host_ready` = 1 after reset.
